// File: rtl/mem_ctrl_pkg.sv
// Shared constants, FSM encoding and address helpers for the line memory controller.
package mem_ctrl_pkg;

  localparam int unsigned WORD_SIZE      = 16;
  localparam int unsigned FETCH_SIZE     = 64;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned TAG_W          = ADDR_W - 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    RD_DRAIN = 3'd2,
    WR       = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Line-aligned part of a word address.
  function automatic logic [TAG_W-1:0] line_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/line_mem_arb.sv
// Two-port tie-break between I and D requesters.
// LINE_MEM_RR_ARB_EN selects round-robin ties; otherwise D always wins a tie.
module line_mem_arb (
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic grant_i,
  output logic grant_d
);

  logic d_wins_tie;

`ifdef LINE_MEM_RR_ARB_EN
  // last_grant is 1 when D was served last, so the other port takes the tie.
  assign d_wins_tie = ~last_grant;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign d_wins_tie        = 1'b1;
`endif

  assign grant_d = req_d & (~req_i | d_wins_tie);
  assign grant_i = req_i & ~grant_d;

endmodule

// File: rtl/line_mem_ctrl.sv
// Serves 64-bit I/D cache line reads and D line writes from a 16-bit backing memory.
// Tie-break policy set by LINE_MEM_RR_ARB_EN inside line_mem_arb.
module line_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_readM,
  input  logic [ADDR_W-1:0]     i_addressM,
  output logic [FETCH_SIZE-1:0] i_dataM,
  output logic                  i_memReady,
  input  logic                  d_readM,
  input  logic                  d_writeM,
  input  logic [ADDR_W-1:0]     d_addressM,
  input  logic [FETCH_SIZE-1:0] d_wdataM,
  output logic [FETCH_SIZE-1:0] d_rdataM,
  output logic                  d_memReady,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic [WORD_SIZE-1:0]  mem_rdata
);

  localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_LINE - 1);

  state_t                  state;
  logic [1:0]              cnt;
  logic                    sel_d;
  logic                    last_grant;
  logic [TAG_W-1:0]        tag_q;
  logic [FETCH_SIZE-1:0]   wdata_q;
  logic [LATENCY-1:0]      pipe_vld;
  logic [1:0]              pipe_idx [LATENCY];

  logic                    grant_i;
  logic                    grant_d;
  logic [ADDR_W-1:0]       req_addr;
  logic                    cap_vld;
  logic [1:0]              cap_idx;
  logic                    unused_addr_lsb;

  assign unused_addr_lsb = ^{i_addressM[1:0], d_addressM[1:0]};

  line_mem_arb u_arb (
    .req_i      (i_readM),
    .req_d      (d_readM | d_writeM),
    .last_grant (last_grant),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  assign req_addr = grant_d ? d_addressM : i_addressM;
  assign cap_vld  = pipe_vld[LATENCY-1];
  assign cap_idx  = pipe_idx[LATENCY-1];

  // Read-return tracker, FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_d      <= 1'b0;
      last_grant <= 1'b0;
      tag_q      <= '0;
      wdata_q    <= '0;
      pipe_vld   <= '0;
      for (int s = 0; s < LATENCY; s++) pipe_idx[s] <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_memReady <= 1'b0;
      d_memReady <= 1'b0;
      i_dataM    <= '0;
      d_rdataM   <= '0;
    end else begin
      // Each issued read word returns LATENCY cycles after its mem_rd cycle.
      pipe_vld[0] <= mem_rd;
      pipe_idx[0] <= cnt;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_idx[s] <= pipe_idx[s-1];
      end

      if (cap_vld) begin
        if (sel_d) d_rdataM[{cap_idx, 4'b0000} +: WORD_SIZE] <= mem_rdata;
        else       i_dataM[{cap_idx, 4'b0000} +: WORD_SIZE]  <= mem_rdata;
      end

      i_memReady <= 1'b0;
      d_memReady <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            tag_q      <= line_tag(req_addr);
            sel_d      <= grant_d;
            last_grant <= grant_d;
            wdata_q    <= d_wdataM;
            cnt        <= '0;
            mem_addr   <= {line_tag(req_addr), 2'b00};
            if (grant_d && d_writeM) begin
              state     <= WR;
              mem_wr    <= 1'b1;
              mem_wdata <= d_wdataM[WORD_SIZE-1:0];
            end else begin
              state  <= RD;
              mem_rd <= 1'b1;
            end
          end
        end

        RD: begin
          if (cnt == LAST_WORD) begin
            state    <= RD_DRAIN;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            cnt      <= '0;
          end else begin
            cnt      <= cnt + 2'd1;
            mem_addr <= {tag_q, cnt + 2'd1};
          end
        end

        RD_DRAIN: begin
          if (cap_vld && cap_idx == LAST_WORD) begin
            state <= DONE;
            if (sel_d) d_memReady <= 1'b1;
            else       i_memReady <= 1'b1;
          end
        end

        WR: begin
          if (cnt == LAST_WORD) begin
            state      <= DONE;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cnt        <= '0;
            d_memReady <= 1'b1;
          end else begin
            cnt       <= cnt + 2'd1;
            mem_addr  <= {tag_q, cnt + 2'd1};
            mem_wdata <= wdata_q[{cnt + 2'd1, 4'b0000} +: WORD_SIZE];
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Self-checking bench for line_mem_ctrl: one LATENCY=1 instance and one LATENCY=3 instance.
// Tie expectations follow LINE_MEM_RR_ARB_EN when defined.
module tb_line_mem_ctrl;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        i_read1, d_read1, d_write1;
  logic [15:0] i_addr1, d_addr1;
  logic [63:0] d_wdata1, i_data1, d_rdata1;
  logic        i_rdy1, d_rdy1;
  logic        mem_rd1, mem_wr1;
  logic [15:0] mem_addr1, mem_wdata1, mem_rdata1;

  logic        i_read3, d_read3, d_write3;
  logic [15:0] i_addr3, d_addr3;
  logic [63:0] d_wdata3, i_data3, d_rdata3;
  logic        i_rdy3, d_rdy3;
  logic        mem_rd3, mem_wr3;
  logic [15:0] mem_addr3, mem_wdata3, mem_rdata3;

  int checks = 0;
  int errors = 0;

  logic [15:0] wr_mem  [logic [15:0]];
  logic [15:0] exp_mem [logic [15:0]];
  logic [16:0] q1 [$];
  logic [16:0] q3 [$];
  logic [16:0] ent1, ent3;

  logic [63:0] exp_i, exp_d;
  bit          last_d;

  always #5 clk = ~clk;

  line_mem_ctrl #(.LATENCY(LAT1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .i_readM(i_read1), .i_addressM(i_addr1), .i_dataM(i_data1), .i_memReady(i_rdy1),
    .d_readM(d_read1), .d_writeM(d_write1), .d_addressM(d_addr1), .d_wdataM(d_wdata1),
    .d_rdataM(d_rdata1), .d_memReady(d_rdy1),
    .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  line_mem_ctrl #(.LATENCY(LAT3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .i_readM(i_read3), .i_addressM(i_addr3), .i_dataM(i_data3), .i_memReady(i_rdy3),
    .d_readM(d_read3), .d_writeM(d_write3), .d_addressM(d_addr3), .d_wdataM(d_wdata3),
    .d_rdataM(d_rdata3), .d_memReady(d_rdy3),
    .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3)
  );

  // Power-on memory image; 0x0120..0x0123 hold 0xA0..0xA3.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a >= 16'h0120 && a <= 16'h0123) return 16'h00A0 + (a - 16'h0120);
    return (a * 16'd40503) ^ 16'h1234;
  endfunction

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return wr_mem.exists(a) ? wr_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_val(a);
  endfunction

  // Backing memories: data for an address issued in cycle c is driven during cycle c+LAT.
  always @(negedge clk) begin
    if (q1.size() >= LAT1) begin
      ent1 = q1.pop_front();
      mem_rdata1 = ent1[16] ? mem_val(ent1[15:0]) : 16'h0000;
    end
    q1.push_back({mem_rd1, mem_addr1});
    if (mem_wr1) wr_mem[mem_addr1] = mem_wdata1;
  end

  always @(negedge clk) begin
    if (q3.size() >= LAT3) begin
      ent3 = q3.pop_front();
      mem_rdata3 = ent3[16] ? mem_val(ent3[15:0]) : 16'h0000;
    end
    q3.push_back({mem_rd3, mem_addr3});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, "_mem_rd"}, 64'(mem_rd1), 64'd0);
    chk({tag, "_mem_wr"}, 64'(mem_wr1), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr1), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata1), 64'd0);
    chk({tag, "_i_rdy"}, 64'(i_rdy1), 64'd0);
    chk({tag, "_d_rdy"}, 64'(d_rdy1), 64'd0);
    chk({tag, "_i_data"}, i_data1, 64'd0);
    chk({tag, "_d_data"}, d_rdata1, 64'd0);
  endtask

  // Called at the negedge of grant cycle T with the request already driven.
  task automatic check_txn(input bit is_d, input bit is_wr, input logic [15:0] addr,
                           input logic [63:0] wdata);
    logic [15:0] base;
    logic [63:0] line;
    int          rdy_at;
    bit          issuing;
    base   = {addr[15:2], 2'b00};
    rdy_at = is_wr ? 5 : 5 + LAT1;
    for (int k = 0; k < 4; k++)
      line[16*k +: 16] = is_wr ? wdata[16*k +: 16] : exp_word(base + 16'(k));
    last_d = is_d;
    for (int n = 1; n <= rdy_at; n++) begin
      @(negedge clk);
      issuing = (n <= 4);
      chk("mem_rd", 64'(mem_rd1), 64'(issuing && !is_wr));
      chk("mem_wr", 64'(mem_wr1), 64'(issuing && is_wr));
      chk("mem_addr", 64'(mem_addr1), issuing ? 64'(base + 16'(n - 1)) : 64'd0);
      chk("mem_wdata", 64'(mem_wdata1),
          (issuing && is_wr) ? 64'(wdata[16*(n-1) +: 16]) : 64'd0);
      chk("i_rdy", 64'(i_rdy1), 64'(n == rdy_at && !is_d));
      chk("d_rdy", 64'(d_rdy1), 64'(n == rdy_at && is_d));
      if (is_wr || is_d)  chk("i_data_hold", i_data1, exp_i);
      if (is_wr || !is_d) chk("d_data_hold", d_rdata1, exp_d);
      if (n == rdy_at && !is_wr) chk(is_d ? "d_line" : "i_line", is_d ? d_rdata1 : i_data1, line);
    end
    if (is_wr) for (int k = 0; k < 4; k++) exp_mem[base + 16'(k)] = wdata[16*k +: 16];
    else if (is_d) exp_d = line;
    else exp_i = line;
    if (is_d) begin d_read1 = 1'b0; d_write1 = 1'b0; end
    else i_read1 = 1'b0;
    @(negedge clk);
    chk("rdy_one_cycle_i", 64'(i_rdy1), 64'd0);
    chk("rdy_one_cycle_d", 64'(d_rdy1), 64'd0);
    chk("idle_mem_rd", 64'(mem_rd1), 64'd0);
    chk("idle_mem_wr", 64'(mem_wr1), 64'd0);
  endtask

  initial begin
    logic [15:0] a, b;
    logic [63:0] w;
    bit          d_first, pick_d, do_wr;

    reset_n = 1'b0;
    {i_read1, d_read1, d_write1, i_addr1, d_addr1, d_wdata1} = '0;
    {i_read3, d_read3, d_write3, i_addr3, d_addr3, d_wdata3} = '0;
    exp_i = '0; exp_d = '0; last_d = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero1("reset");
    chk("reset_l3_rdy", 64'(d_rdy3), 64'd0);
    chk("reset_l3_mem_rd", 64'(mem_rd3), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Lone I read of line 0x0120.
    i_read1 = 1'b1; i_addr1 = 16'h0123;
    check_txn(1'b0, 1'b0, 16'h0123, '0);
    chk("i_read_known_line", i_data1, 64'h00A3_00A2_00A1_00A0);

    // Lone D write.
    d_write1 = 1'b1; d_addr1 = 16'h0040; d_wdata1 = 64'h4444_3333_2222_1111;
    check_txn(1'b1, 1'b1, 16'h0040, 64'h4444_3333_2222_1111);

    // Read and write together act as a write; re-asserted read returns written line.
    d_read1 = 1'b1; d_write1 = 1'b1; d_addr1 = 16'h0202; d_wdata1 = 64'hDEAD_BEEF_CAFE_F00D;
    check_txn(1'b1, 1'b1, 16'h0202, 64'hDEAD_BEEF_CAFE_F00D);
    d_read1 = 1'b1; d_addr1 = 16'h0201;
    check_txn(1'b1, 1'b0, 16'h0201, '0);
    chk("write_then_read_line", d_rdata1, 64'hDEAD_BEEF_CAFE_F00D);

    // Simultaneous I and D reads; the loser waits for the next IDLE.
    for (int t = 0; t < 3; t++) begin
      a = 16'($urandom); b = 16'($urandom);
`ifdef LINE_MEM_RR_ARB_EN
      d_first = ~last_d;
`else
      d_first = 1'b1;
`endif
      i_read1 = 1'b1; i_addr1 = a;
      d_read1 = 1'b1; d_addr1 = b;
      if (d_first) begin
        check_txn(1'b1, 1'b0, b, '0);
        check_txn(1'b0, 1'b0, a, '0);
      end else begin
        check_txn(1'b0, 1'b0, a, '0);
        check_txn(1'b1, 1'b0, b, '0);
      end
    end

    // Random single transactions.
    for (int t = 0; t < 16; t++) begin
      pick_d = 1'($urandom_range(0, 1));
      do_wr  = pick_d & 1'($urandom_range(0, 1));
      a      = 16'($urandom);
      w      = {$urandom, $urandom};
      if (pick_d) begin
        d_addr1 = a; d_wdata1 = w;
        d_write1 = do_wr;
        d_read1  = !do_wr || 1'($urandom_range(0, 1));
      end else begin
        i_addr1 = a; i_read1 = 1'b1;
      end
      check_txn(pick_d, do_wr, a, w);
    end

    // Reset during RD at T+3 abandons the line.
    i_read1 = 1'b1; i_addr1 = 16'($urandom);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk_zero1("mid_reset");
    reset_n = 1'b1; i_read1 = 1'b0;
    exp_i = '0; exp_d = '0; last_d = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("post_reset_i_rdy", 64'(i_rdy1), 64'd0);
      chk("post_reset_mem_rd", 64'(mem_rd1), 64'd0);
    end
    a = 16'($urandom);
    i_read1 = 1'b1; i_addr1 = a;
    check_txn(1'b0, 1'b0, a, '0);

    // LATENCY=3 instance: D reads complete at T+8.
    for (int t = 0; t < 3; t++) begin
      a = 16'($urandom);
      for (int k = 0; k < 4; k++) w[16*k +: 16] = exp_word({a[15:2], 2'(k)});
      d_read3 = 1'b1; d_addr3 = a;
      for (int n = 1; n <= 8; n++) begin
        @(negedge clk);
        chk("l3_mem_rd", 64'(mem_rd3), 64'(n <= 4));
        chk("l3_d_rdy", 64'(d_rdy3), 64'(n == 8));
        if (n == 8) chk("l3_d_line", d_rdata3, w);
      end
      d_read3 = 1'b0;
      @(negedge clk);
      chk("l3_rdy_one_cycle", 64'(d_rdy3), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_mem_ctrl.md
LINE_MEM_CTRL -- requirements
Module: line_mem_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 1; backing-memory read latency in cycles (1..3).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports i_readM in 1, i_addressM in 16, i_dataM out 64, i_memReady out 1; I-cache line-read port.
REQ-005 SHALL have ports d_readM in 1, d_writeM in 1, d_addressM in 16, d_wdataM in 64, d_rdataM out 64, d_memReady out 1; D-cache line port.
REQ-006 SHALL have ports mem_rd out 1, mem_wr out 1, mem_addr out 16, mem_wdata out 16, mem_rdata in 16; one word-wide backing memory.

Function
REQ-007 SHALL treat a request as level: requester holds readM/writeM until its memReady pulse; a request still high in the cycle after memReady SHALL be a new request.
REQ-008 SHALL use line base {addr[15:2],2'b00}; word k (0..3) at {addr[15:2],k}, mapped to line bits [16k+15:16k].
REQ-009 SHALL have states IDLE, RD, RD_DRAIN, WR, DONE; IDLE->RD (read grant), IDLE->WR (write grant), RD->RD_DRAIN after word 3 issued, RD_DRAIN->DONE when word 3 captured, WR->DONE after word 3 written, DONE->IDLE.
REQ-010 SHALL latch address, write data and granted port in the IDLE cycle the grant is made (cycle T).
REQ-011 SHALL assert mem_rd for cycles T+1..T+4, word k at T+1+k, and capture mem_rdata LATENCY cycles after each issue.
REQ-012 SHALL pulse the granted port's memReady for exactly one cycle in DONE: read at T+5+LATENCY, write at T+5.
REQ-013 SHALL hold i_dataM/d_rdataM stable from memReady until that port's next read captures word 0; write transactions SHALL NOT alter d_rdataM.
REQ-014 SHALL assert mem_wr for cycles T+1..T+4 with mem_wdata = d_wdataM word k at T+1+k.
REQ-015 SHALL never assert mem_rd and mem_wr in the same cycle; mem_addr/mem_wdata SHALL be 0 when both are low.
REQ-016 SHALL treat d_readM and d_writeM both high as a write; the read is ignored until re-requested after d_memReady.
REQ-017 SHALL evaluate arbitration only in IDLE; requests arriving mid-transaction SHALL wait, none dropped.
REQ-018 SHALL grant a sole requester immediately; tie rule per REQ-021.
REQ-019 SHALL make word-index counter wrap 3->0 only on leaving RD/WR; no partial lines.

Reset
REQ-020 SHALL, when reset_n low at a clock edge, including mid-transaction, go to IDLE, abandon the in-flight line, and clear mem_rd, mem_wr, mem_addr, mem_wdata, i_memReady, d_memReady, i_dataM, d_rdataM and arbitration history to 0.

Configuration
REQ-021 SHALL honour macro LINE_MEM_RR_ARB_EN: defined -> round-robin tie-break, port not granted last wins (after reset, D wins first tie); undefined -> fixed priority, D always wins ties.

Structure
REQ-022 SHALL take from shared package mem_ctrl_pkg: WORD_SIZE=16, FETCH_SIZE=64, WORDS_PER_LINE=4, state encodings.
REQ-023 SHALL place the two-port tie-break in sub-module line_mem_arb (req_i, req_d, last_grant -> grant_i, grant_d), the only part affected by LINE_MEM_RR_ARB_EN.

Verification
REQ-024 SHALL cover I read alone: i_readM, addr 0x0123, memory 0x0120..0x0123 = 0xA0,0xA1,0xA2,0xA3 -> mem_rd addrs 0x0120..0x0123, i_dataM = 0x00A3_00A2_00A1_00A0, i_memReady pulse at T+6 (LATENCY=1).
REQ-025 SHALL cover D write: d_writeM, addr 0x0040, d_wdataM 0x4444_3333_2222_1111 -> mem_wr words 0x1111,0x2222,0x3333,0x4444 to 0x0040..0x0043, d_memReady at T+5, d_rdataM unchanged.
REQ-026 SHALL cover tie: i_readM and d_readM same cycle -> D served first, I granted in IDLE after D's DONE; build with LINE_MEM_RR_ARB_EN, second tie -> I served first.
REQ-027 SHALL cover write-then-read: d_writeM+d_readM high -> write only, ready pulse; d_readM re-asserted -> read returns written line.
REQ-028 SHALL cover reset mid-RD (cycle T+3) -> next edge all outputs 0, state IDLE, no memReady; fresh request afterwards completes normally.
REQ-029 SHALL cover LATENCY=3 read -> d_memReady at T+8, data correct.
